// File: rtl/barrel_shift_unit.sv
// barrel_shift_unit: two-stage pipelined barrel shifter/rotator with lane-loaded source and auto-step amount
module barrel_shift_unit #(
    parameter int WIDTH = 16,
    parameter int IN_W = 8,
    parameter int TICK_DIV = 100_000_000,
    localparam int SHW = $clog2(WIDTH),
    localparam int LANES = WIDTH / IN_W,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [LW-1:0]    in_select,
    input  logic             wr,
    input  logic [IN_W-1:0]  in,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   sel,
    input  logic             load,
    output logic [WIDTH-1:0] out,
    output logic [SHW-1:0]   amt,
    output logic             upd
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [SHW-1:0] LO_MASK = SHW'((1 << ((SHW + 1) / 2)) - 1);

    logic [WIDTH-1:0] src;
    logic [PW-1:0]    pre;
    logic [SHW-1:0]   cnt;
    logic             tick;
    logic [WIDTH-1:0] s1_d;
    logic [2:0]       s1_op;
    logic [SHW-1:0]   s1_n;
    logic [WIDTH-1:0] out_nxt;

    // Shifting by the low and high amount bits in separate stages composes exactly for every op.
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d, input logic [2:0] o,
                                                  input logic [SHW-1:0] n);
        logic [WIDTH-1:0] fill;
        fill = ~({WIDTH{1'b1}} >> n) & {WIDTH{d[WIDTH-1]}};
        return (o == 3'd0) ? (d << n) | (d >> (WIDTH - int'(n))) :
               (o == 3'd1) ? (d >> n) | (d << (WIDTH - int'(n))) :
               (o == 3'd2) ? d << n :
               (o == 3'd3) ? d >> n :
               (o == 3'd4) ? (d >> n) | fill : d;
    endfunction

    always_comb begin
        tick = mode && (pre == PW'(TICK_DIV - 1));
        amt = mode ? cnt : sel;
        out_nxt = shift_by(s1_d, s1_op, s1_n & ~LO_MASK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src <= '0;
        end else if (wr && int'(in_select) < LANES) begin
            src[in_select*IN_W +: IN_W] <= in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            cnt <= '0;
        end else if (load) begin
            pre <= '0;
            cnt <= sel;
        end else if (mode) begin
            pre <= tick ? '0 : pre + 1'b1;
            cnt <= tick ? cnt + 1'b1 : cnt;
        end else begin
            pre <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_d  <= '0;
            s1_op <= '0;
            s1_n  <= '0;
            out   <= '0;
            upd   <= 1'b0;
        end else begin
            s1_d  <= shift_by(src, op, amt & LO_MASK);
            s1_op <= op;
            s1_n  <= amt;
            out   <= out_nxt;
            upd   <= out_nxt != out;
        end
    end
endmodule

// File: tb/tb_barrel_shift_unit.sv
// tb_barrel_shift_unit: directed and swept checks of barrel_shift_unit (WIDTH=16, IN_W=8, TICK_DIV=4)
module tb_barrel_shift_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        in_select = 1'b0;
    logic        wr = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  din = '0;
    logic [2:0]  op = '0;
    logic [3:0]  sel = '0;
    logic [15:0] out;
    logic [3:0]  amt;
    logic        upd;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    barrel_shift_unit #(.WIDTH(16), .IN_W(8), .TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_select(in_select), .wr(wr), .in(din),
        .op(op), .sel(sel), .load(load), .out(out), .amt(amt), .upd(upd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_op(input logic [15:0] d, input logic [2:0] o, input int n);
        logic [15:0] r;
        r = d;
        for (int b = 0; b < 16; b++) begin
            case (o)
                3'd0: r[(b + n) % 16] = d[b];
                3'd1: r[b] = d[(b + n) % 16];
                3'd2: r[b] = (b >= n) ? d[(b - n) & 15] : 1'b0;
                3'd3: r[b] = (b + n < 16) ? d[(b + n) & 15] : 1'b0;
                3'd4: r[b] = (b + n < 16) ? d[(b + n) & 15] : d[15];
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 1'b1;
        step();
        step();
        checks++; if (out !== 16'h0) begin failures++; $display("FAIL reset_out got=%h exp=0000", out); end
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL reset_upd got=%b exp=0", upd); end
        checks++; if (amt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", amt); end
        mode = 1'b0;
        rst_n = 1'b1;
        in_select = 1'b1; din = 8'h7F; wr = 1'b1;
        step();
        in_select = 1'b0; din = 8'hFF;
        step();
        wr = 1'b0;
        step();
        step();
        checks++; if (out !== 16'h7FFF) begin failures++; $display("FAIL load_src got=%h exp=7fff", out); end
        step();
        step();
    endtask

    task automatic test_ops_7fff();
        logic [2:0]  ops[4]  = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [3:0]  sels[4] = '{4'd1, 4'd1, 4'd4, 4'd4};
        logic [15:0] exps[4] = '{16'hFFFE, 16'hBFFF, 16'hFFF0, 16'h07FF};
        logic [15:0] prev = 16'h7FFF;
        for (int i = 0; i < 4; i++) begin
            op = ops[i]; sel = sels[i];
            step();
            checks++; if (out !== prev) begin failures++; $display("FAIL ops7fff_early[%0d] got=%h exp=%h", i, out, prev); end
            step();
            checks++; if (out !== exps[i]) begin failures++; $display("FAIL ops7fff[%0d] got=%h exp=%h", i, out, exps[i]); end
            checks++; if (upd !== 1'b1) begin failures++; $display("FAIL ops7fff_upd[%0d] got=%b exp=1", i, upd); end
            step();
            checks++; if (upd !== 1'b0) begin failures++; $display("FAIL ops7fff_upd_end[%0d] got=%b exp=0", i, upd); end
            prev = exps[i];
        end
    endtask

    task automatic test_ops_8001();
        logic [2:0]  ops[4]  = '{3'd4, 3'd3, 3'd1, 3'd7};
        logic [3:0]  sels[4] = '{4'd3, 4'd3, 4'd15, 4'd6};
        logic [15:0] exps[4] = '{16'hF000, 16'h1000, 16'h0003, 16'h8001};
        logic [15:0] prev = 16'h8001;
        in_select = 1'b1; din = 8'h80; wr = 1'b1;
        step();
        in_select = 1'b0; din = 8'h01;
        step();
        wr = 1'b0; op = 3'd7;
        repeat (4) step();
        checks++; if (out !== prev) begin failures++; $display("FAIL pass_8001 got=%h exp=%h", out, prev); end
        for (int i = 0; i < 4; i++) begin
            op = ops[i]; sel = sels[i];
            step();
            step();
            checks++; if (out !== exps[i]) begin failures++; $display("FAIL ops8001[%0d] got=%h exp=%h", i, out, exps[i]); end
            checks++; if (upd !== 1'b1) begin failures++; $display("FAIL ops8001_upd[%0d] got=%b exp=1", i, upd); end
            step();
        end
    endtask

    task automatic test_auto();
        mode = 1'b1; load = 1'b1; sel = 4'd0;
        step();
        load = 1'b0;
        checks++; if (amt !== 4'd0) begin failures++; $display("FAIL auto_load0 got=%0d exp=0", amt); end
        for (int i = 1; i <= 16; i++) begin
            repeat (3) step();
            checks++; if (amt !== 4'((i - 1) % 16)) begin failures++; $display("FAIL auto_hold[%0d] got=%0d exp=%0d", i, amt, (i - 1) % 16); end
            step();
            checks++; if (amt !== 4'(i % 16)) begin failures++; $display("FAIL auto_step[%0d] got=%0d exp=%0d", i, amt, i % 16); end
        end
        repeat (3) step();
        load = 1'b1; sel = 4'd5;
        step();
        load = 1'b0;
        checks++; if (amt !== 4'd5) begin failures++; $display("FAIL load_vs_tick got=%0d exp=5", amt); end
        repeat (3) step();
        checks++; if (amt !== 4'd5) begin failures++; $display("FAIL load_pre_clear got=%0d exp=5", amt); end
        step();
        checks++; if (amt !== 4'd6) begin failures++; $display("FAIL load_next_tick got=%0d exp=6", amt); end
        mode = 1'b0; sel = 4'd9;
        #1;
        checks++; if (amt !== 4'd9) begin failures++; $display("FAIL manual_amt got=%0d exp=9", amt); end
        repeat (10) step();
        mode = 1'b1;
        #1;
        checks++; if (amt !== 4'd6) begin failures++; $display("FAIL freeze got=%0d exp=6", amt); end
        mode = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] src_m = 16'h8001;
        logic [15:0] e, e_prev = '0, e_prev2 = '0;
        mode = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (i < 128) begin
                op = 3'(i / 16); sel = 4'(i % 16);
            end else begin
                op = 3'($urandom_range(7)); sel = 4'($urandom_range(15));
            end
            wr = ($urandom_range(3) == 0);
            in_select = 1'($urandom_range(1));
            din = 8'($urandom);
            e = ref_op(src_m, op, int'(sel));
            if (wr) src_m[int'(in_select)*8 +: 8] = din;
            step();
            if (i >= 1) begin
                checks++; if (out !== e_prev) begin failures++; $display("FAIL sweep_out[%0d] got=%h exp=%h", i, out, e_prev); end
            end
            if (i >= 2) begin
                checks++; if (upd !== (e_prev != e_prev2)) begin failures++; $display("FAIL sweep_upd[%0d] got=%b exp=%b", i, upd, e_prev != e_prev2); end
            end
            e_prev2 = e_prev;
            e_prev = e;
        end
        wr = 1'b0;
    endtask

    task automatic test_reset_async();
        mode = 1'b1; in_select = 1'b0; din = 8'h55; wr = 1'b1; op = 3'd7;
        step();
        wr = 1'b0;
        repeat (3) step();
        checks++; if (out === 16'h0) begin failures++; $display("FAIL pre_reset_out got=%h exp=nonzero", out); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (out !== 16'h0) begin failures++; $display("FAIL async_out got=%h exp=0000", out); end
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL async_upd got=%b exp=0", upd); end
        checks++; if (amt !== 4'd0) begin failures++; $display("FAIL async_amt got=%0d exp=0", amt); end
        mode = 1'b0;
        step();
        rst_n = 1'b1;
        in_select = 1'b0; din = 8'hAA; wr = 1'b1; op = 3'd0; sel = 4'd0;
        step();
        wr = 1'b0;
        checks++; if (out !== 16'h0) begin failures++; $display("FAIL post_rst_e0 got=%h exp=0000", out); end
        step();
        checks++; if (out !== 16'h0) begin failures++; $display("FAIL post_rst_e1 got=%h exp=0000", out); end
        step();
        checks++; if (out !== 16'h00AA) begin failures++; $display("FAIL post_rst_wr got=%h exp=00aa", out); end
        checks++; if (upd !== 1'b1) begin failures++; $display("FAIL post_rst_upd got=%b exp=1", upd); end
    endtask

    initial begin
        test_reset();
        test_ops_7fff();
        test_ops_8001();
        test_auto();
        test_back_to_back();
        test_reset_async();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/barrel_shift_unit.md
# barrel_shift_unit

Parametrised, pipelined barrel shifter/rotator for the Nexys-class lab designs. It assembles a WIDTH-bit operand from IN_W-bit switch lanes and applies one of five shift/rotate operations. The shift amount comes either from the sel switches (manual) or from an internal step counter advanced by a prescaled tick (auto). The registered result feeds the seven-segment display driver, together with the current amount and a change strobe.

## Interface
- WIDTH, 16: operand width; power of two, ≥ 8.
- IN_W, 8: lane width of the data input; WIDTH must be a multiple of IN_W.
- TICK_DIV, 100_000_000: clk cycles per auto-mode step (1 s at 100 MHz); ≥ 2.
- Derived: SHW = clog2(WIDTH); LW = max(1, clog2(WIDTH/IN_W)).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = manual (amount = sel); 1 = auto (amount = step counter).
- in_select  in  LW  lane index written by wr; lane k = src[k*IN_W +: IN_W].
- wr  in  1  write in into the selected lane this cycle.
- in  in  IN_W  lane data.
- op  in  3  000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, others = pass-through.
- sel  in  SHW  manual shift amount / load value for the step counter.
- load  in  1  load sel into the step counter.
- out  out  WIDTH  registered result.
- amt  out  SHW  amount currently applied (manual: sel; auto: counter), for display.
- upd  out  1  one-cycle pulse when out changes value.

## Operation
- Source register src (WIDTH): on wr, lane in_select ← in; other lanes hold. An out-of-range in_select is ignored.
- Step counter cnt (SHW), prescaler pre (counts 0..TICK_DIV-1):
  - mode=0: pre held at 0; cnt holds.
  - mode=1: pre increments; at TICK_DIV-1 it wraps to 0 and emits a tick; tick → cnt+1, wrapping WIDTH-1 → 0.
  - load (either mode): cnt ← sel, pre ← 0. load beats a same-cycle tick.
- amt = mode ? cnt : sel. Combinational; amt follows sel directly in manual mode.
- Operations on d = src, amount n:
  - ROL/ROR: circular.
  - SLL/SRL: zero fill.
  - SRA: fills with d[WIDTH-1].
  - n = 0: d unchanged for every op.
- Pipeline, log-shifter of SHW stages split in two:
  - Stage 1 registers op, n, d and applies the lower ceil(SHW/2) stages.
  - Stage 2 applies the remaining stages into out.
  - SRA and pass-through carry their fill/op through both stages.
- upd: high in the cycle after the edge where out took a value different from its previous value.
- Reset (async assert, any time including mid-shift):
  - src, cnt, pre, both pipeline stages and out ← 0; upd ← 0.
  - Effect is immediate, without waiting for a clock edge.
  - Release is synchronised by the caller. The first active edge after release behaves as normal operation.

## Timing
- op/sel/mode sampled at edge E → out valid after E+1 (latency 2 edges).
- wr at edge E updates src at E → out reflects it after E+2.
- load at edge E → cnt = sel after E → out uses it after E+2.
- Auto tick: cnt changes on the edge where pre wraps. out follows 2 edges later; upd pulses in the following cycle.
- Full throughput: a new operation every cycle; no stalls, no backpressure.
- Simultaneous wr and op/sel change in the same cycle: out first shows the new op on old src, then the new op on new src one cycle later.

## Test plan
- Reset, then with WIDTH=16 write lane1=0x7F and lane0=0xFF → src 0x7FFF. Check out=0x7FFF with op=ROL, sel=0; out and cnt are 0 during reset.
- src 0x7FFF: ROL 1 → 0xFFFE; ROR 1 → 0xBFFF; SLL 4 → 0xFFF0; SRL 4 → 0x07FF. Each valid exactly 2 edges after the sel/op change, with one upd pulse per change.
- src 0x8001: SRA 3 → 0xF000; SRL 3 → 0x1000; ROR 15 → 0x0003; op=111 → 0x8001.
- Auto mode with TICK_DIV=4: cnt steps 0,1,…,15,0 every 4 cycles and amt tracks cnt. load with sel=5 coincident with a tick → cnt=5 and pre=0. Switching to mode=0 freezes cnt.
- Sweep sel 0..15 for each op against a reference model on random src over 1000 back-to-back cycles; out matches with 2-edge latency and no missed updates.
- Assert rst_n mid-sweep between clock edges → out, amt (auto), and upd are 0 immediately. After release, a wr of 0xAA to lane0 → out=0x00AA two edges later.
